// File: rtl/ex_pkg.sv
// Shared types for the EX issue stage: ALU opcode enum, issue entry, and the
// operand-forwarding helper used by the issue slots.
package ex_pkg;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'b0000,
      ALU_SUB  = 4'b1000,
      ALU_SLL  = 4'b0001,
      ALU_SLT  = 4'b0010,
      ALU_SLTU = 4'b0011,
      ALU_XOR  = 4'b0100,
      ALU_SRL  = 4'b0101,
      ALU_SRA  = 4'b1101,
      ALU_OR   = 4'b0110,
      ALU_AND  = 4'b0111
   } alu_ctrl_e;

   typedef struct packed {
      logic [31:0] rs1;
      logic [31:0] rs2;
      logic [4:0]  rs1_addr;
      logic [4:0]  rs2_addr;
      logic [4:0]  rd_addr;
      alu_ctrl_e   alu_ctrl;
      logic        use_imm;
   } issue_entry_t;

   // x0 is hardwired, so a writeback to index 0 never updates an operand;
   // an immediate in rs2 is never a register and is never replaced.
   function automatic issue_entry_t fwd_apply(input issue_entry_t e,
                                              input logic         fv,
                                              input logic [4:0]   fa,
                                              input logic [31:0]  fd);
      issue_entry_t r;
      r = e;
      if (fv && (fa != 5'd0)) begin
         if (e.rs1_addr == fa)
            r.rs1 = fd;
         if (!e.use_imm && (e.rs2_addr == fa))
            r.rs2 = fd;
      end
      return r;
   endfunction

endpackage

// File: rtl/ex_issue_slot.sv
// One issue-buffer entry: valid flag plus payload register with writeback
// forwarding applied on every edge (active only when EX_ISSUE_FWD_EN is defined).
module ex_issue_slot
   import ex_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         valid_next,
   input  logic         load,
   input  issue_entry_t entry_in,
   input  logic         fwd_valid,
   input  logic [4:0]   fwd_addr,
   input  logic [31:0]  fwd_data,
   output logic         valid,
   output issue_entry_t entry
);

   issue_entry_t src;
   issue_entry_t entry_next;

   assign src = load ? entry_in : entry;

`ifdef EX_ISSUE_FWD_EN
   assign entry_next = fwd_apply(src, fwd_valid, fwd_addr, fwd_data);
`else
   logic unused_fwd;
   assign unused_fwd = ^{fwd_valid, fwd_addr, fwd_data};
   assign entry_next = src;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= 1'b0;
         entry <= '0;
      end else begin
         valid <= valid_next;
         entry <= entry_next;
      end
   end

endmodule

// File: rtl/ex_issue_buf.sv
// Two-entry (main + skid) issue buffer between decode and the ALU, with a
// registered in_ready and optional operand forwarding (macro EX_ISSUE_FWD_EN).
module ex_issue_buf
   import ex_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        flush,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_rs1_data,
   input  logic [31:0] in_rs2_data,
   input  logic [31:0] in_imm,
   input  logic        in_use_imm,
   input  logic [3:0]  in_alu_ctrl,
   input  logic [4:0]  in_rs1_addr,
   input  logic [4:0]  in_rs2_addr,
   input  logic [4:0]  in_rd_addr,
   input  logic        fwd_valid,
   input  logic [4:0]  fwd_addr,
   input  logic [31:0] fwd_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_rs1,
   output logic [31:0] out_rs2,
   output logic [3:0]  out_alu_ctrl,
   output logic [4:0]  out_rd_addr
);

   issue_entry_t in_entry;
   issue_entry_t main_entry;
   issue_entry_t skid_entry;
   issue_entry_t main_src;
   logic         main_valid;
   logic         skid_valid;
   logic         main_vnext;
   logic         main_load;
   logic         skid_vnext;
   logic         skid_load;
   logic         in_ready_reg;
   logic         accept;
   logic         drain;
   logic         main_free;

   always_comb begin
      in_entry.rs1      = in_rs1_data;
      in_entry.rs2      = in_use_imm ? in_imm : in_rs2_data;
      in_entry.rs1_addr = in_rs1_addr;
      in_entry.rs2_addr = in_rs2_addr;
      in_entry.rd_addr  = in_rd_addr;
      in_entry.alu_ctrl = alu_ctrl_e'(in_alu_ctrl);
      in_entry.use_imm  = in_use_imm;
   end

   assign accept    = in_valid && in_ready_reg;
   assign drain     = main_valid && out_ready;
   assign main_free = !main_valid || drain;

   // in_ready is only high while skid is empty, so an accept never collides
   // with a skid-to-main move.
   always_comb begin
      main_vnext = main_valid;
      main_load  = 1'b0;
      main_src   = in_entry;
      skid_vnext = skid_valid;
      skid_load  = 1'b0;
      if (flush) begin
         main_vnext = 1'b0;
         skid_vnext = 1'b0;
      end else if (main_free) begin
         if (skid_valid) begin
            main_vnext = 1'b1;
            main_load  = 1'b1;
            main_src   = skid_entry;
            skid_vnext = accept;
            skid_load  = accept;
         end else begin
            main_vnext = accept;
            main_load  = accept;
         end
      end else if (accept) begin
         skid_vnext = 1'b1;
         skid_load  = 1'b1;
      end
   end

   ex_issue_slot u_main (
      .clk        (clk),
      .rst_n      (rst_n),
      .valid_next (main_vnext),
      .load       (main_load),
      .entry_in   (main_src),
      .fwd_valid  (fwd_valid),
      .fwd_addr   (fwd_addr),
      .fwd_data   (fwd_data),
      .valid      (main_valid),
      .entry      (main_entry)
   );

   ex_issue_slot u_skid (
      .clk        (clk),
      .rst_n      (rst_n),
      .valid_next (skid_vnext),
      .load       (skid_load),
      .entry_in   (in_entry),
      .fwd_valid  (fwd_valid),
      .fwd_addr   (fwd_addr),
      .fwd_data   (fwd_data),
      .valid      (skid_valid),
      .entry      (skid_entry)
   );

   // Held low through reset so upstream cannot push until the first edge after release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         in_ready_reg <= 1'b0;
      else
         in_ready_reg <= !skid_vnext;
   end

   assign in_ready     = in_ready_reg;
   assign out_valid    = main_valid;
   assign out_rs1      = main_entry.rs1;
   assign out_rs2      = main_entry.rs2;
   assign out_alu_ctrl = main_entry.alu_ctrl;
   assign out_rd_addr  = main_entry.rd_addr;

   logic unused_main;
   assign unused_main = ^{main_entry.rs1_addr, main_entry.rs2_addr, main_entry.use_imm};

endmodule
